// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter sizing for the serializer
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic int cnt_w(input int w);
        return (w < 3) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, framed serial bitstream out
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             xfer;

    assign in_ready = (state == IDLE) | (state == SHIFT && cnt == '0);
    assign xfer     = in_valid & in_ready;
    assign shifted  = LSB_FIRST ? shift_reg >> 1 : shift_reg << 1;
    assign busy     = serial_valid;

    // shift_reg always holds the bit currently on serial_out at its output end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            cnt          <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
        end else if (xfer) begin
            state        <= SHIFT;
            shift_reg    <= in_data;
            cnt          <= CW'(WIDTH - 1);
            serial_out   <= LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
            serial_valid <= 1'b1;
            frame_start  <= 1'b1;
            frame_end    <= 1'b0;
        end else if (state == SHIFT && cnt != '0) begin
            shift_reg    <= shifted;
            cnt          <= cnt - CW'(1);
            serial_out   <= LSB_FIRST ? shifted[0] : shifted[WIDTH-1];
            serial_valid <= 1'b1;
            frame_start  <= 1'b0;
            frame_end    <= (cnt == CW'(1));
        end else begin
            state        <= IDLE;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of the serializer feeding a 3-stage SIPO
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_data;
    logic       in_valid;
    logic       in_ready, serial_out, serial_valid, frame_start, frame_end, busy;
    logic [3:0] in_data1;
    logic       in_valid1;
    logic       in_ready1, serial_out1, serial_valid1, frame_start1, frame_end1, busy1;
    logic [2:0] sipo;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    piso_serializer u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .serial_out(serial_out), .serial_valid(serial_valid),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .serial_out(serial_out1), .serial_valid(serial_valid1),
        .frame_start(frame_start1), .frame_end(frame_end1), .busy(busy1)
    );

    // downstream SIPO: newest bit enters at the MSB
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sipo <= '0;
        else if (serial_valid) sipo <= {serial_out, sipo[2:1]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".sv"}, serial_valid, 0);
        check({tag, ".so"}, serial_out, 0);
        check({tag, ".fs"}, frame_start, 0);
        check({tag, ".fe"}, frame_end, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".rdy"}, in_ready, 1);
    endtask

    // one word, one-cycle valid; bits[i] is the expected bit in cycle i+1
    task automatic frame3(input string tag, input logic [2:0] w, input logic [2:0] bits);
        in_valid = 1'b1;
        in_data  = w;
        check({tag, ".rdy0"}, in_ready, 1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("%s.sv%0d", tag, c), serial_valid, 1);
            check($sformatf("%s.so%0d", tag, c), serial_out, bits[c-1]);
            check($sformatf("%s.fs%0d", tag, c), frame_start, c == 1);
            check($sformatf("%s.fe%0d", tag, c), frame_end, c == 3);
        end
        @(negedge clk);
        check({tag, ".sipo"}, sipo, w);
        check({tag, ".end"}, serial_valid, 0);
    endtask

    // two words; the second is raised in cycle c_next and held until accepted
    task automatic stream(input string tag, input logic [2:0] w0, input logic [2:0] w1,
                          input int c_next, input logic [6:0] rdy, input logic [5:0] bits);
        in_valid = 1'b1;
        in_data  = w0;
        check({tag, ".rdy0"}, in_ready, rdy[0]);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("%s.sv%0d", tag, c), serial_valid, 1);
            check($sformatf("%s.so%0d", tag, c), serial_out, bits[c-1]);
            check($sformatf("%s.rdy%0d", tag, c), in_ready, rdy[c]);
            check($sformatf("%s.fs%0d", tag, c), frame_start, c == 1 || c == 4);
            check($sformatf("%s.fe%0d", tag, c), frame_end, c == 3 || c == 6);
            if (c == 1) begin
                in_valid = (c_next == 1);
                in_data  = w1;
            end
            if (c == c_next) in_valid = 1'b1;
            if (c == 4) in_valid = 1'b0;
        end
        @(negedge clk);
        check({tag, ".sipo"}, sipo, w1);
        check({tag, ".end"}, serial_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 3'b111;
        in_valid1 = 1'b0;
        in_data1  = '0;
        repeat (3) @(negedge clk);
        check_idle("rst");
        check("rst.msb_sv", serial_valid1, 0);
        check("rst.msb_rdy", in_ready1, 1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check_idle("post_rst");
        check("post_rst.sipo", sipo, 0);

        frame3("single", 3'b110, 3'b110);
        stream("b2b", 3'b101, 3'b011, 1, 7'b1001001, 6'b011101);
        stream("stall", 3'b100, 3'b010, 2, 7'b1001001, 6'b010100);

        in_valid = 1'b1;
        in_data  = 3'b111;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid.sv", serial_valid, 1);
        check("mid.so", serial_out, 1);
        #1 rst_n = 1'b0;
        #1 check_idle("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("mid_rel");
        frame3("after_rst", 3'b001, 3'b001);

        in_valid1 = 1'b1;
        in_data1  = 4'b1000;
        check("msb.rdy0", in_ready1, 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            in_valid1 = 1'b0;
            check($sformatf("msb.sv%0d", c), serial_valid1, 1);
            check($sformatf("msb.so%0d", c), serial_out1, c == 1);
            check($sformatf("msb.fs%0d", c), frame_start1, c == 1);
            check($sformatf("msb.fe%0d", c), frame_end1, c == 4);
        end
        @(negedge clk);
        check("msb.end", serial_valid1, 0);
        check("msb.rdy", in_ready1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer that sits directly upstream of the 3-bit serial-in/parallel-out shift register. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `serial_out`, with framing strobes. With default parameters, the downstream SIPO holds the exact input word on its parallel output once the last bit has been shifted in. Words can be streamed back-to-back with no idle bubble.

## Interface
- `WIDTH`, 3: word width in bits; legal range 2..32.
- `LSB_FIRST`, 1: 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in WIDTH: word to serialize; sampled only on a handshake.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block can accept a word this cycle.
- `serial_out` out 1: serial data bit; registered; 0 when `serial_valid`=0.
- `serial_valid` out 1: `serial_out` carries a frame bit this cycle.
- `frame_start` out 1: high with the first bit of each word.
- `frame_end` out 1: high with the last bit of each word.
- `busy` out 1: a frame is in progress (equals `serial_valid`).

## Operation
- **States:** IDLE, SHIFT.
- **Handshake:** a transfer occurs on a rising edge where `in_valid`=1 and `in_ready`=1.
- `in_ready` = (state==IDLE) | (state==SHIFT & bit counter==0). It is combinational from registered state only, with no path from `in_valid`.
- **IDLE + transfer:** load the shift register with `in_data`, set the counter to WIDTH-1, go to SHIFT, and assert `frame_start` on the next cycle.
- **SHIFT:**
  - Each edge shifts the register one position toward the output end and decrements the counter.
  - The output bit is shift_reg[0] when `LSB_FIRST`=1, else shift_reg[WIDTH-1].
- **Counter==0 (last bit):**
  - `frame_end`=1.
  - A transfer on this edge reloads the register and stays in SHIFT, with `frame_start` on the next cycle.
  - With no transfer, the block returns to IDLE.
- **Stalls:** `in_valid` while the counter is nonzero is not accepted. The upstream holds `in_data`/`in_valid` until `in_ready`.
- **Width rules:** the counter is max(1, $clog2(WIDTH)) bits. It never wraps below 0; the state transition occurs at 0.
- **Reset values (async, immediate):** state=IDLE, shift register=0, counter=0, `serial_out`=0, `serial_valid`=0, `frame_start`=0, `frame_end`=0, `busy`=0, `in_ready`=1. Handshakes while `rst_n`=0 are ignored.
- **Reset mid-frame:** the frame is dropped with no partial completion. After release, the next accepted word is transmitted in full.

## Timing
- **Latency:** a transfer at edge k puts the first bit on `serial_out` in the cycle after edge k.
- **Frame length:** each frame occupies exactly WIDTH consecutive `serial_valid` cycles.
- **Throughput:** one word per WIDTH cycles when `in_valid` is held high, with zero gap cycles.
- **Single-bit cycle:** `frame_start` and `frame_end` never coincide, since WIDTH≥2.
- **Downstream capture:** at the edge that closes the `frame_end` cycle, a WIDTH-stage SIPO (newest bit in its MSB) contains `in_data` when `LSB_FIRST`=1.

## Structure
- **Shared package `piso_pkg`:**
  - state enum {IDLE, SHIFT}.
  - function cnt_w(WIDTH) returning max(1, $clog2(WIDTH)).
- **Sub-modules:** none. The shift register, counter and FSM stay inline in one module.
- **Verification wrapper:** the testbench instantiates `piso_serializer` feeding the existing SIPO for end-to-end checks.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0 and `in_ready`=1. Assert `in_valid` with 3'b111 during reset → no frame produced.
- **Single word:** `in_data`=3'b110, LSB_FIRST=1, one-cycle `in_valid` at edge k:
  - `serial_out` = 0,1,1 in cycles k+1..k+3.
  - `frame_start` in cycle k+1; `frame_end` in cycle k+3.
  - SIPO `parallel_out`=3'b110 after edge k+3.
- **Back-to-back:** send 3'b101 then 3'b011 with `in_valid` held high:
  - 6 consecutive `serial_valid` cycles with bits 1,0,1,1,1,0.
  - `in_ready` high only in cycles 0, 3 and 6.
- **Stall:** present 3'b010 while the first frame is mid-flight (counter=1) → not accepted. It is accepted at the last-bit edge and its bits 0,1,0 follow with no gap.
- **Reset mid-frame:** assert `rst_n`=0 after the first bit of 3'b111 → outputs go to 0 asynchronously in the same cycle. After release, send 3'b001 → full frame 1,0,0.
- **MSB-first:** LSB_FIRST=0, WIDTH=4, `in_data`=4'b1000 → `serial_out` = 1,0,0,0, with `frame_end` on the 4th bit.
